// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings and defaults.
package uart_program_loader_pkg;

  // 100 MHz / 115200 baud.
  localparam int UART_CLKS_PER_BIT = 868;

  // The image header is a little-endian word count of this many bytes.
  localparam int LOADER_COUNT_BYTES = 2;

  typedef enum logic [1:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DRAIN
  } loader_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_program_loader_if.sv
// Write port between the loader (master) and program memory (slave).
interface uart_program_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] write_addr;   // program_mem.in_write_addr
  logic [WORD_WIDTH-1:0] write_data;   // program_mem.in_write_data
  logic                  write_ready;  // program_mem.in_write_ready
  logic                  write_done;   // program_mem.out_write_ready_reg

  modport master (
    output write_addr,
    output write_data,
    output write_ready,
    input  write_done
  );

  modport slave (
    input  write_addr,
    input  write_data,
    input  write_ready,
    output write_done
  );

endinterface

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch and framing checks.
module uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic      meta_q, sync_q;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic      valid_q, valid_d;
  logic      ferr_q, ferr_d;

  // Synchronizer presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= in_rx;
      sync_q <= meta_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timing: half a bit to mid-start, then one full bit per data/stop sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that is already high again at mid-bit was a glitch.
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sync_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        // Do not mistake a held-low line for a new start bit.
        if (sync_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // shift_q only moves again once the next byte's data bits arrive.
  assign out_data      = shift_q;
  assign out_valid     = valid_q;
  assign out_frame_err = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a length-prefixed program image from UART into program memory.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int WORD_WIDTH   = 32,
  parameter int CAPACITY     = 1024,
  parameter int ADDR_WIDTH   = $clog2(CAPACITY)
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic                   in_uart_rx,
  uart_program_loader_if.master  wr,
  output logic                   out_busy,
  output logic                   out_done,
  output logic                   out_error
);

  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int BCW            = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int COUNT_WIDTH    = 8 * LOADER_COUNT_BYTES;
  localparam logic [BCW-1:0]        BYTE_LAST = BCW'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_WIDTH:0]   CAP_LIMIT = (ADDR_WIDTH + 1)'(CAPACITY);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_rx        (in_uart_rx),
    .out_data     (rx_data),
    .out_valid    (rx_valid),
    .out_frame_err(rx_frame_err)
  );

  loader_state_t state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [WORD_WIDTH-1:0]  asm_q, asm_d, asm_shift;
  logic                   word_valid_q, word_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   wr_ready_q, wr_ready_d;
  // Number of writes acknowledged this image; one extra bit exposes CAPACITY overflow.
  logic [ADDR_WIDTH:0]    acked_q, acked_d;
  logic [ADDR_WIDTH:0]    next_addr;
  logic                   write_ack;

  // Little-endian assembly: each byte enters the top lane and older bytes move down,
  // so the first byte of a word ends up in bits [7:0].
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      if (gi == BYTES_PER_WORD - 1) begin : g_top
        assign asm_shift[8*gi +: 8] = rx_data;
      end else begin : g_low
        assign asm_shift[8*gi +: 8] = asm_q[8*(gi+1) +: 8];
      end
    end
  endgenerate

  assign write_ack = wr_ready_q & wr.write_done;

  // Loader state and write-port registers.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= S_LEN0;
      count_q      <= '0;
      len_lo_q     <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_ready_q   <= 1'b0;
      acked_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_lo_q     <= len_lo_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_ready_q   <= wr_ready_d;
      acked_q      <= acked_d;
    end
  end

  // Header parsing, word assembly and the single-slot write handshake.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    len_lo_d     = len_lo_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    word_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_ready_d   = wr_ready_q;
    acked_d      = acked_q;
    // An ack in the same cycle frees the slot, so the new word takes the next address.
    next_addr    = acked_q + {{ADDR_WIDTH{1'b0}}, write_ack};

    if (write_ack) begin
      acked_d    = acked_q + (ADDR_WIDTH + 1)'(1);
      wr_ready_d = 1'b0;
    end

    // A completed word one cycle after its last byte: issue, or drop it and flag.
    if (word_valid_q) begin
      if (wr_ready_q && !write_ack) begin
        error_d = 1'b1;
      end else if (next_addr >= CAP_LIMIT) begin
        error_d = 1'b1;
      end else begin
        wr_addr_d  = next_addr[ADDR_WIDTH-1:0];
        wr_data_d  = asm_q;
        wr_ready_d = 1'b1;
      end
    end

    if (rx_frame_err) error_d = 1'b1;

    case (state_q)
      S_LEN0: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          busy_d   = 1'b1;
          error_d  = 1'b0;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (rx_valid) begin
          count_d    = {rx_data, len_lo_q};
          acked_d    = '0;
          byte_cnt_d = '0;
          // An empty image goes straight to the done pulse via the drain state.
          state_d    = ({rx_data, len_lo_q} == '0) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          asm_d = asm_shift;
          if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_d   = '0;
            word_valid_d = 1'b1;
            count_d      = count_q - COUNT_WIDTH'(1);
            if (count_q == COUNT_WIDTH'(1)) state_d = S_DRAIN;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!word_valid_q && !wr_ready_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_LEN0;
        end
      end
      default: state_d = S_LEN0;
    endcase
  end

  assign wr.write_addr  = wr_addr_q;
  assign wr.write_data  = wr_data_q;
  assign wr.write_ready = wr_ready_q;
  assign out_busy       = busy_q;
  assign out_done       = done_q;
  assign out_error      = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized self-checking bench for uart_program_loader with a word-level reference model.
module tb_uart_program_loader;

  localparam int CPB     = 4;
  localparam int WW      = 16;
  localparam int CAP     = 8;
  localparam int AW      = 3;
  localparam int BPW     = WW / 8;
  localparam int SPACING = BPW * 10 * CPB;  // cycles between back-to-back words

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic busy, done, err;

  uart_program_loader_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) wr_if ();

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .WORD_WIDTH  (WW),
    .CAPACITY    (CAP),
    .ADDR_WIDTH  (AW)
  ) dut (
    .in_clk    (clk),
    .in_rst    (rst),
    .in_uart_rx(rx),
    .wr        (wr_if),
    .out_busy  (busy),
    .out_done  (done),
    .out_error (err)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  ack_delay = 3;
  int  wait_cnt  = 0;
  int  done_cnt  = 0;
  longint done_time = 0;
  longint stop_time = 0;
  logic prev_busy = 1'b0;
  logic [AW-1:0] cap_addr;
  logic [WW-1:0] cap_data;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  byte_q[$];
  bit  exp_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Program memory model plus done/busy monitor, all sampled on the falling edge.
  initial begin
    wr_if.write_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_if.write_done = 1'b0;
        wait_cnt  = 0;
        prev_busy = 1'b0;
      end else begin
        wr_if.write_done = 1'b0;
        if (wr_if.write_ready) begin
          if (wait_cnt == 0) begin
            cap_addr = wr_if.write_addr;
            cap_data = wr_if.write_data;
          end
          wait_cnt++;
          if (wait_cnt >= ack_delay) begin
            check_eq("wr_hold_addr", 32'(wr_if.write_addr), 32'(cap_addr));
            check_eq("wr_hold_data", 32'(wr_if.write_data), 32'(cap_data));
            obs_q.push_back('{int'(wr_if.write_addr), int'(wr_if.write_data)});
            $display("[TB] write addr=%0d data=0x%04h", wr_if.write_addr, wr_if.write_data);
            wr_if.write_done = 1'b1;
            wait_cnt = 0;
          end
        end
        if (done) begin
          done_cnt++;
          done_time = $time;
          check_eq("busy_low_at_done", 32'(busy), 32'd0);
          check_eq("busy_high_before_done", 32'(prev_busy), 32'd1);
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    stop_time = $time;
    bit_time(stop_ok);
    rx = 1'b1;
  endtask

  // Reference: words are little-endian byte pairs, addressed in order of successful
  // writes; dropped for capacity, or when the previous write is still outstanding.
  task automatic model_image(input int n, input int ackd);
    int addr;
    int last_issue;
    int word;
    exp_q.delete();
    exp_err    = 1'b0;
    addr       = 0;
    last_issue = -1;
    for (int w = 0; w < n; w++) begin
      word = byte_q[2*w] | (byte_q[2*w+1] << 8);
      if (last_issue >= 0 && (ackd + 3) > SPACING * (w - last_issue)) begin
        exp_err = 1'b1;
      end else if (addr >= CAP) begin
        exp_err = 1'b1;
      end else begin
        exp_q.push_back('{addr, word});
        addr++;
        last_issue = w;
      end
    end
  endtask

  task automatic wait_done(input string tag, input int start_cnt);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != start_cnt) break;
      @(negedge clk);
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt != start_cnt), 32'd1);
    idle(6);
    check_eq({tag, "_done_once"}, 32'(done_cnt - start_cnt), 32'd1);
  endtask

  task automatic compare_writes(input string tag);
    check_eq({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq({tag, "_addr"}, 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      check_eq({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
  endtask

  task automatic run_image(input string tag, input int n, input int gap_max,
                           input int ackd, input bit cap_probe);
    int start;
    ack_delay = ackd;
    model_image(n, ackd);
    obs_q.delete();
    start = done_cnt;
    send_byte(8'(n), 1'b1);
    idle(6);
    check_eq({tag, "_hdr_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_hdr_clears_err"}, 32'(err), 32'd0);
    send_byte(8'(n >> 8), 1'b1);
    idle($urandom_range(0, gap_max));
    for (int i = 0; i < n * BPW; i++) begin
      send_byte(8'(byte_q[i]), 1'b1);
      if (cap_probe && i == 2*CAP - 1) begin
        idle(6);
        check_eq({tag, "_err_before_cap"}, 32'(err), 32'd0);
      end
      if (cap_probe && i == 2*CAP + 1) begin
        idle(6);
        check_eq({tag, "_err_at_cap"}, 32'(err), 32'd1);
      end
      idle($urandom_range(0, gap_max));
    end
    wait_done(tag, start);
    compare_writes(tag);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    $display("[TB] image %s n=%0d writes=%0d err=%0b", tag, n, obs_q.size(), err);
    ack_delay = 3;
  endtask

  task automatic fill_random(input int nbytes);
    byte_q.delete();
    for (int i = 0; i < nbytes; i++) byte_q.push_back(int'($urandom_range(0, 255)));
  endtask

  initial begin
    int start;
    int lat;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_if.write_ready), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_if.write_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_if.write_data), 32'd0);
    rst = 1'b0;
    idle(10);

    // Two-word image with prompt acks.
    byte_q = '{32'h34, 32'h12, 32'h78, 32'h56};
    run_image("basic", 2, 0, 3, 1'b0);

    // Empty image: done follows the second header byte's stop bit closely.
    obs_q.delete();
    start = done_cnt;
    send_byte(8'h00, 1'b1);
    idle(6);
    check_eq("empty_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b1);
    wait_done("empty", start);
    lat = int'((done_time - stop_time) / 10);
    check_eq("empty_done_latency_ok", 32'(lat >= CPB/2 + 2 && lat <= CPB + 8), 32'd1);
    check_eq("empty_nwrites", 32'(obs_q.size()), 32'd0);
    check_eq("empty_err", 32'(err), 32'd0);
    $display("[TB] image empty done %0d cycles after stop bit start", lat);

    // Framing error while idle, then an image that clears it.
    send_byte(8'h55, 1'b0);
    idle(8);
    check_eq("frame_err_set", 32'(err), 32'd1);
    check_eq("frame_err_not_busy", 32'(busy), 32'd0);
    byte_q = '{32'hAA, 32'hBB};
    run_image("frame", 1, 0, 3, 1'b0);

    // More words than capacity.
    fill_random(20);
    run_image("cap", 10, 0, 3, 1'b1);

    // Slow memory: second back-to-back word overruns the pending write.
    fill_random(4);
    run_image("ovr", 2, 0, 100, 1'b0);

    // Reset in the middle of the third data byte.
    byte_q = '{32'h11, 32'h22};
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_err", 32'(err), 32'd0);
    check_eq("midrst_wr_ready", 32'(wr_if.write_ready), 32'd0);
    check_eq("midrst_wr_addr", 32'(wr_if.write_addr), 32'd0);
    check_eq("midrst_wr_data", 32'(wr_if.write_data), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);
    byte_q = '{32'hEF, 32'hBE};
    run_image("postrst", 1, 0, 3, 1'b0);

    // One-cycle low glitch while idle must not be taken as a byte.
    obs_q.delete();
    start = done_cnt;
    rx = 1'b0;
    @(negedge clk);
    idle(60);
    check_eq("glitch_busy", 32'(busy), 32'd0);
    check_eq("glitch_err", 32'(err), 32'd0);
    check_eq("glitch_done", 32'(done_cnt - start), 32'd0);
    check_eq("glitch_nwrites", 32'(obs_q.size()), 32'd0);

    // Random images with random inter-byte gaps.
    for (int k = 0; k < 5; k++) begin
      int n;
      n = int'($urandom_range(1, 4));
      fill_random(n * BPW);
      run_image($sformatf("rand%0d", k), n, 5, 3, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Receives a program image over the UART RX pin (8N1) and assembles the bytes into program-memory words.
- Writes each word into program_mem through that memory's write port (in_write_addr / in_write_data / in_write_ready / out_write_ready_reg).
- Sits between the in_UART_RX top-level pin and program_mem.
- Drives out_busy so the peripheral controller can hold the system in reset while loading.

Parameters:
- CLKS_PER_BIT, 868, in_clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- WORD_WIDTH, 32, program word width; must be a multiple of 8 (equals PROGRAM_MEM_WORD_WIDTH).
- CAPACITY, 1024, program memory depth in words (equals PROGRAM_MEM_CAPACITY).
- ADDR_WIDTH, $clog2(CAPACITY), write address width.

Ports:
- in_clk  input  1  system clock
- in_rst  input  1  asynchronous, active-high reset
- in_uart_rx  input  1  raw UART RX line; idle high; asynchronous to in_clk
- out_write_addr  output  ADDR_WIDTH  word address to program_mem.in_write_addr
- out_write_data  output  WORD_WIDTH  word to program_mem.in_write_data
- out_write_ready  output  1  write request to program_mem.in_write_ready
- in_write_done  input  1  completion from program_mem.out_write_ready_reg
- out_busy  output  1  high from the first header byte until the final write completes
- out_done  output  1  one-cycle pulse when an image finishes
- out_error  output  1  sticky error flag; cleared when the next header byte is accepted

Behaviour:
- Reset (async, in_rst=1): every output is 0; FSM goes to S_LEN0; UART RX goes idle; the synchronizer is preset to 1.
- RX path:
  - 2-flop synchronizer on in_uart_rx.
  - A falling edge starts the bit counter.
  - Start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, it is a glitch → return to idle.
  - Data bits are sampled LSB first every CLKS_PER_BIT cycles from mid-start.
  - Stop bit is sampled at mid-bit:
    - stop = 1 → one-cycle byte_valid with byte_data.
    - stop = 0 → framing error: byte dropped, out_error = 1, RX waits for the line to go high, then returns to idle.
- Frame format: 2-byte little-endian word count N, followed by N*BYTES_PER_WORD data bytes. Each word is little-endian (first byte → bits [7:0]).
- FSM states:
  - S_LEN0: a byte → N[7:0]; out_busy = 1; out_error cleared → S_LEN1.
  - S_LEN1: a byte → N[15:8].
    - If N == 0: out_done pulses the next cycle, out_busy = 0 → S_LEN0.
    - Otherwise, address = 0 → S_DATA.
  - S_DATA: bytes shift into the assembly register; a byte counter wraps at BYTES_PER_WORD. When a word completes:
    - Write slot free → latch addr/data into out_write_addr/out_write_data and set out_write_ready = 1 the next cycle.
    - Address >= CAPACITY → word is discarded without a write and out_error = 1.
    - Word count decrements; the last word → S_DRAIN.
  - S_DRAIN: wait until no write is pending; then out_done pulses for 1 cycle, out_busy = 0 → S_LEN0.
- Write handshake:
  - out_write_ready stays high, with addr/data stable, until a cycle in which in_write_done = 1. It deasserts the following cycle and the address increments.
  - in_write_done while out_write_ready = 0 is ignored.
  - Minimum latency from the final stop-bit sample to out_write_ready is 2 cycles.
- Overrun: a new word completes while the previous write is still pending → the new word is dropped, out_error = 1, the count still decrements (no stall).
- Simultaneous events: completion and acceptance in the same cycle is not overrun; the new word is latched and out_write_ready stays high.
- Reset mid-image: aborts immediately; the next image restarts at address 0. A partially assembled word is discarded.
- Counts wider than 16 bits are not supported. Address arithmetic is ADDR_WIDTH + 1 bits so that the CAPACITY overflow is detectable.

Decomposition:
- Shared package / parameters.vh:
  - Loader FSM state encodings (S_LEN0, S_LEN1, S_DATA, S_DRAIN).
  - UART_CLKS_PER_BIT default.
  - LOADER_COUNT_BYTES = 2.
- Sub-module: uart_rx (synchronizer, bit timing, framing check), with ports in_clk, in_rst, in_rx, out_data[7:0], out_valid, out_frame_err. The loader instantiates it once.

Test Plan (CLKS_PER_BIT=4, WORD_WIDTH=16, CAPACITY=8; memory model acks 3 cycles after a request):
- Send bytes 02 00 34 12 78 56 → writes (0, 0x1234), (1, 0x5678); one out_done pulse; out_busy falls on the same cycle; out_error = 0.
- Send 00 00 → no writes; out_done 2 cycles after the second stop sample; out_busy high for exactly that window.
- Send 0x55 with stop bit = 0, then 01 00 AA BB → first image: out_error = 1; the following 01 00 clears it; write (0, 0xBBAA).
- Send header 0A 00 plus 20 data bytes → addresses 0–7 written; words 8–9 dropped; out_error = 1 at word 8; out_done still pulses.
- Memory ack delayed 100 cycles with back-to-back words → second word dropped, out_error = 1, first write held stable until ack.
- Assert in_rst mid-bit during the 3rd data byte, then send 01 00 EF BE → all outputs 0 on the reset edge; then write (0, 0xBEEF).
- 1-cycle low glitch on RX while idle → no byte_valid, no state change.
